xpt_phase_sequencer: RTL

//  Sequences the decoder chain through execution phases (XPT0..XPTn) for each instruction.

---
 rtl/xpt_phase_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/xpt_phase_sequencer.sv
// Steps the decoder chain through active-low one-hot execution phases per instruction.
// Optional stall counter built when XPT_STALL_COUNT_EN is defined.
module xpt_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Stall,
  input  logic                  InstrValid,
  input  logic                  EndOfInstr,
  input  logic                  notChainEnd,
  output logic                  FetchReq,
  output logic                  not_decodingIn,
  output logic [NUM_PHASES-1:0] notXPT,
  output logic [PHASE_W-1:0]    Phase,
  output logic                  Busy,
  output logic                  InstrRetired,
  output logic                  IllegalOp,
  output logic [15:0]           StallCycles
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    TRAP
  } state_t;

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);

  state_t             state;
  state_t             nxt_state;
  logic [PHASE_W-1:0] nxt_phase;
  logic               claim_miss;

  // An unclaimed opcode traps, so it must never count as a retire.
  assign claim_miss   = (Phase == '0) && !notChainEnd;
  assign InstrRetired = (state == EXEC) && !Stall
                        && EndOfInstr && !claim_miss;

  always_comb begin
    nxt_state = state;
    nxt_phase = Phase;
    if (!Stall) begin
      unique case (state)
        IDLE: begin
          if (Run) nxt_state = FETCH;
        end
        FETCH: begin
          if (InstrValid) begin
            nxt_state = EXEC;
            nxt_phase = '0;
          end
        end
        EXEC: begin
          if (claim_miss) begin
            nxt_state = TRAP;
            nxt_phase = '0;
          end else if (EndOfInstr) begin
            nxt_state = Run ? FETCH : IDLE;
            nxt_phase = '0;
          end else if (Phase == LAST) begin
            nxt_state = TRAP;
            nxt_phase = '0;
          end else begin
            nxt_phase = Phase + PHASE_W'(1);
          end
        end
        TRAP: begin
          nxt_state = TRAP;
          nxt_phase = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      Phase          <= '0;
      FetchReq       <= 1'b0;
      not_decodingIn <= 1'b1;
      notXPT         <= '1;
      Busy           <= 1'b0;
      IllegalOp      <= 1'b0;
    end else begin
      state          <= nxt_state;
      Phase          <= nxt_phase;
      FetchReq       <= (nxt_state == FETCH);
      not_decodingIn <= (nxt_state != EXEC);
      notXPT         <= (nxt_state == EXEC)
                        ? ~(NUM_PHASES'(1) << nxt_phase)
                        : '1;
      Busy           <= (nxt_state == FETCH) || (nxt_state == EXEC);
      IllegalOp      <= (nxt_state == TRAP);
    end
  end

`ifdef XPT_STALL_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
    end else if (Stall && Busy && (StallCycles != 16'hFFFF)) begin
      StallCycles <= StallCycles + 16'd1;
    end
  end
`else
  assign StallCycles = 16'h0000;
`endif

endmodule
